core_ins_fetch_unit: RTL and testbench
======================================

CORE_INS_FETCH_UNIT -- requirements
Module: core_ins_fetch_unit

Interface
REQ-001 SHALL have parameter INSTRUCTION_WIDTH, default 64, meaning bits per instruction.
REQ-002 SHALL have parameter BURST_SLOTS, default 64, meaning instructions per burst.
REQ-003 SHALL have parameter BURST_WIDTH, default 4096 (INSTRUCTION_WIDTH*BURST_SLOTS), meaning burst bus width.
REQ-004 SHALL have port clk  input  1  system clock, rising edge.
REQ-005 SHALL have port RSTn  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port start  input  1  single-cycle pulse that begins program fetch.
REQ-007 SHALL have port prog_start_addr  input  16  first instruction address, sampled on start.
REQ-008 SHALL have port prog_end_addr  input  16  last instruction address (inclusive), sampled on start.
REQ-009 SHALL have port fetch_req  output  1  single-cycle burst request to the tile instruction memory.
REQ-010 SHALL have port start_ins_addr  output  16  burst first address, valid while fetch_req=1.
REQ-011 SHALL have port end_ins_addr  output  16  burst last address, valid while fetch_req=1.
REQ-012 SHALL have port burst_valid  input  1  burst_data is valid this cycle.
REQ-013 SHALL have port burst_data  input  BURST_WIDTH  slot k at bits [k*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH].
REQ-014 SHALL have port ins_valid  output  1  ins_data holds an instruction for the core decoder.
REQ-015 SHALL have port ins_data  output  INSTRUCTION_WIDTH  current instruction.
REQ-016 SHALL have port ins_ready  input  1  decoder accepts ins_data this cycle.
REQ-017 SHALL have port busy  output  1  high in every state except IDLE.
REQ-018 SHALL have port done  output  1  single-cycle pulse at program completion.

Function
REQ-019 SHALL implement the FSM states IDLE, REQ, WAIT, ISSUE and DONE.
REQ-020 In IDLE, start=1 SHALL latch pc=prog_start_addr and last=prog_end_addr, then go to REQ; if prog_end_addr<prog_start_addr it SHALL go to DONE with no request.
REQ-021 In REQ, fetch_req=1 for exactly one cycle with start_ins_addr=pc and end_ins_addr=min(pc+BURST_SLOTS-1, last); the sum SHALL be computed in 17 bits so that no wrap occurs; next state WAIT.
REQ-022 In WAIT, burst_valid=1 SHALL capture burst_data into the slot buffer, set count=end_ins_addr-start_ins_addr+1 and idx=0, and go to ISSUE one cycle later.
REQ-023 burst_valid SHALL be ignored in every state except WAIT, and WAIT SHALL hold indefinitely without burst_valid.
REQ-024 In ISSUE, ins_valid=1 and ins_data=slot[idx] SHALL be registered outputs, stable until ins_ready=1.
REQ-025 On ins_valid&&ins_ready, idx and pc SHALL increment; on the acceptance of slot count-1 the FSM SHALL go to DONE if the accepted address equals last, else to REQ.
REQ-026 Back-to-back acceptance SHALL sustain one instruction per cycle within a burst; the burst-to-burst gap SHALL be REQ+WAIT+fill latency (at least 3 cycles).
REQ-027 DONE SHALL assert done for one cycle and then return to IDLE.
REQ-028 start SHALL be ignored while busy=1.
REQ-029 ins_valid SHALL be 0 outside ISSUE; ins_data SHALL be 0 whenever ins_valid=0.
REQ-030 last=16'hFFFF SHALL terminate correctly with no pc wrap to 0.

Reset
REQ-031 RSTn=0 SHALL immediately force IDLE and fetch_req, start_ins_addr, end_ins_addr, ins_valid, ins_data, busy, done, pc, idx and count to 0, including mid-burst; slot buffer contents are don't-care.
REQ-032 After RSTn deasserts, no request SHALL issue until a new start.

Configuration
REQ-033 Macro FETCH_ZERO_STOP_EN: when defined, an all-zero slot reached in ISSUE SHALL not be presented and SHALL move the FSM to DONE (end-of-program marker); when undefined, zero slots SHALL be issued as ordinary instructions.

Verification
REQ-034 start, range 0x0000..0x0009, ins_ready=1 -> one fetch_req with 0x0000/0x0009; 10 instructions issued on consecutive cycles; then done pulse.
REQ-035 range 0x0100..0x0180 -> requests 0x0100/0x013F, 0x0140/0x017F and 0x0180/0x0180; 129 instructions in order; one done.
REQ-036 ins_ready toggling 1-0-1 during ISSUE -> ins_data held while ready=0; no instruction lost or duplicated.
REQ-037 RSTn pulled low in WAIT and again in ISSUE at idx=5 -> all outputs 0 next sample; a later burst_valid is ignored; restart works.
REQ-038 range 0xFFC0..0xFFFF -> end_ins_addr=0xFFFF, 64 issued, done, no further request; range 0x0005..0x0004 -> done with no fetch_req.
REQ-039 With FETCH_ZERO_STOP_EN, slot 3 = 0 in a 10-instruction range -> 3 issued, then done; without the macro -> 10 issued, including the zero instruction.

Source files
------------

// File: rtl/core_ins_fetch_unit.sv
// Instruction fetch unit: pulls a program range from tile instruction memory in bursts
// and hands it to the decoder one instruction per handshake. Optional macro: FETCH_ZERO_STOP_EN.
module core_ins_fetch_unit #(
    parameter int INSTRUCTION_WIDTH = 64,
    parameter int BURST_SLOTS       = 64,
    parameter int BURST_WIDTH       = INSTRUCTION_WIDTH * BURST_SLOTS
) (
    input  logic                         clk,
    input  logic                         RSTn,
    input  logic                         start,
    input  logic [15:0]                  prog_start_addr,
    input  logic [15:0]                  prog_end_addr,
    output logic                         fetch_req,
    output logic [15:0]                  start_ins_addr,
    output logic [15:0]                  end_ins_addr,
    input  logic                         burst_valid,
    input  logic [BURST_WIDTH-1:0]       burst_data,
    output logic                         ins_valid,
    output logic [INSTRUCTION_WIDTH-1:0] ins_data,
    input  logic                         ins_ready,
    output logic                         busy,
    output logic                         done,
    output logic [2:0]                   fsm_state
);

    localparam int IDX_W  = $clog2(BURST_SLOTS + 1);
    localparam int SLOT_W = (BURST_SLOTS > 1) ? $clog2(BURST_SLOTS) : 1;

`ifdef FETCH_ZERO_STOP_EN
    localparam bit ZERO_STOP = 1'b1;
`else
    localparam bit ZERO_STOP = 1'b0;
`endif

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [15:0]                  pc;
    logic [15:0]                  last;
    logic [15:0]                  burst_end;
    logic [IDX_W-1:0]             idx;
    logic [IDX_W-1:0]             count;
    logic [BURST_WIDTH-1:0]       slot_buf;
    logic [16:0]                  span_sum;
    logic [15:0]                  span_end;
    logic [SLOT_W-1:0]            next_slot;
    logic [INSTRUCTION_WIDTH-1:0] next_word;
    logic [INSTRUCTION_WIDTH-1:0] first_word;
    logic                         accept;
    logic                         last_slot;

    // Burst end is clipped to the program end; 17-bit sum so a range near 0xFFFF never wraps.
    always_comb begin
        span_sum   = {1'b0, pc} + 17'(BURST_SLOTS - 1);
        span_end   = (span_sum > {1'b0, last}) ? last : span_sum[15:0];
        next_slot  = SLOT_W'(idx + IDX_W'(1));
        next_word  = slot_buf[next_slot*INSTRUCTION_WIDTH +: INSTRUCTION_WIDTH];
        first_word = burst_data[INSTRUCTION_WIDTH-1:0];
        accept     = (state == S_ISSUE) && ins_valid && ins_ready;
        last_slot  = (idx == count - IDX_W'(1));
    end

    assign fetch_req      = (state == S_REQ);
    assign start_ins_addr = fetch_req ? pc : 16'd0;
    assign end_ins_addr   = fetch_req ? span_end : 16'd0;
    assign busy           = (state != S_IDLE);
    assign done           = (state == S_DONE);
    assign fsm_state      = state;

    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (start)
                    state_next = (prog_end_addr < prog_start_addr) ? S_DONE : S_REQ;
            end
            S_REQ:  state_next = S_WAIT;
            S_WAIT: begin
                if (burst_valid)
                    state_next = (ZERO_STOP && first_word == '0) ? S_DONE : S_ISSUE;
            end
            S_ISSUE: begin
                if (accept) begin
                    if (last_slot)
                        state_next = (pc == last) ? S_DONE : S_REQ;
                    else if (ZERO_STOP && next_word == '0)
                        state_next = S_DONE;
                end
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Decoder handshake: ins_valid/ins_data are registered and held unchanged until a
    // rising edge sees ins_valid && ins_ready; that edge is the transfer of ins_data.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            pc        <= 16'd0;
            last      <= 16'd0;
            burst_end <= 16'd0;
            idx       <= '0;
            count     <= '0;
            slot_buf  <= '0;
            ins_valid <= 1'b0;
            ins_data  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        pc   <= prog_start_addr;
                        last <= prog_end_addr;
                    end
                end
                S_REQ: burst_end <= span_end;
                S_WAIT: begin
                    if (burst_valid) begin
                        slot_buf <= burst_data;
                        count    <= IDX_W'(burst_end - pc + 16'd1);
                        idx      <= '0;
                        if (state_next == S_ISSUE) begin
                            ins_valid <= 1'b1;
                            ins_data  <= first_word;
                        end
                    end
                end
                S_ISSUE: begin
                    if (accept) begin
                        idx <= idx + IDX_W'(1);
                        if (state_next == S_ISSUE) begin
                            pc       <= pc + 16'd1;
                            ins_data <= next_word;
                        end else begin
                            ins_valid <= 1'b0;
                            ins_data  <= '0;
                            // Final address of the program keeps pc from wrapping past 0xFFFF.
                            if (pc != last) pc <= pc + 16'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_core_ins_fetch_unit.sv
// Self-checking bench for core_ins_fetch_unit: memory responder, randomized decoder
// back-pressure, and a range-level reference model of requests and issued instructions.
module tb_core_ins_fetch_unit;

  localparam int IW = 64;
  localparam int NS = 64;
  localparam int BW = IW * NS;

`ifdef FETCH_ZERO_STOP_EN
  localparam bit ZERO_STOP = 1'b1;
`else
  localparam bit ZERO_STOP = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          RSTn = 1'b0;
  logic          start = 1'b0;
  logic [15:0]   prog_start_addr = 16'd0;
  logic [15:0]   prog_end_addr = 16'd0;
  logic          fetch_req;
  logic [15:0]   start_ins_addr;
  logic [15:0]   end_ins_addr;
  logic          burst_valid = 1'b0;
  logic [BW-1:0] burst_data = '0;
  logic          ins_valid;
  logic [IW-1:0] ins_data;
  logic          ins_ready = 1'b0;
  logic          busy;
  logic          done;
  logic [2:0]    fsm_state;

  always #5 clk = ~clk;

  core_ins_fetch_unit #(
    .INSTRUCTION_WIDTH(IW),
    .BURST_SLOTS(NS),
    .BURST_WIDTH(BW)
  ) dut (
    .clk(clk),
    .RSTn(RSTn),
    .start(start),
    .prog_start_addr(prog_start_addr),
    .prog_end_addr(prog_end_addr),
    .fetch_req(fetch_req),
    .start_ins_addr(start_ins_addr),
    .end_ins_addr(end_ins_addr),
    .burst_valid(burst_valid),
    .burst_data(burst_data),
    .ins_valid(ins_valid),
    .ins_data(ins_data),
    .ins_ready(ins_ready),
    .busy(busy),
    .done(done),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int          n_checks = 0;
  int          n_fails = 0;
  logic [15:0] word_tag = 16'h0;
  int          zero_addr = -1;
  logic [IW-1:0] exp_q[$];
  logic [15:0]   req_s_q[$];
  logic [15:0]   req_e_q[$];

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory contents: a unique non-zero word per address, except an optional zero marker.
  function automatic logic [IW-1:0] word(input int a);
    logic [15:0] lo;
    lo = a[15:0];
    if (a == zero_addr) return '0;
    return {word_tag, lo, ~lo, word_tag ^ 16'h5A5A};
  endfunction

  function automatic logic [BW-1:0] build_burst(input int base, input int n);
    logic [BW-1:0] d;
    for (int k = 0; k < NS; k++)
      d[k*IW +: IW] = (k < n) ? word(base + k) : {$urandom, $urandom};
    return d;
  endfunction

  task automatic check_all_zero(input string pfx);
    check_value({pfx, "_fetch_req"}, 64'(fetch_req), 64'd0);
    check_value({pfx, "_start_addr"}, 64'(start_ins_addr), 64'd0);
    check_value({pfx, "_end_addr"}, 64'(end_ins_addr), 64'd0);
    check_value({pfx, "_ins_valid"}, 64'(ins_valid), 64'd0);
    check_value({pfx, "_ins_data"}, ins_data, 64'd0);
    check_value({pfx, "_busy"}, 64'(busy), 64'd0);
    check_value({pfx, "_done"}, 64'(done), 64'd0);
    check_value({pfx, "_state_idle"}, 64'(fsm_state), 64'd0);
  endtask

  // ---------------- driver: one full program ----------------
  // mode 0: always ready, mode 1: random ready + stray starts, mode 2: ready toggles
  task automatic run_program(input int s, input int e, input int mode, input int zaddr);
    int cyc, done_cnt, done_cyc, n_acc, first_acc, last_acc, delay, n_exp, bbase, bn, be;
    bit outstanding, hold_pending, first_req;
    logic [IW-1:0] held;
    logic [15:0] es, ee;
    word_tag = 16'($urandom);
    zero_addr = zaddr;
    exp_q.delete();
    req_s_q.delete();
    req_e_q.delete();
    for (int a = s; a <= e; a++) begin
      if (ZERO_STOP && a == zero_addr) break;
      exp_q.push_back(word(a));
    end
    for (int b = s; b <= e; b += NS) begin
      be = (b + NS - 1 > e) ? e : b + NS - 1;
      req_s_q.push_back(16'(b));
      req_e_q.push_back(16'(be));
      if (ZERO_STOP && zero_addr >= b && zero_addr <= be) break;
    end
    n_exp = exp_q.size();
    cyc = 0; done_cnt = 0; done_cyc = 0; n_acc = 0; first_acc = 0; last_acc = 0;
    delay = 0; bbase = 0; bn = 0;
    outstanding = 0; hold_pending = 0; first_req = 1; held = '0;
    ins_ready = 1'b1;
    @(negedge clk);
    start = 1'b1;
    prog_start_addr = 16'(s);
    prog_end_addr = 16'(e);
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (fetch_req) begin
        if (req_s_q.size() == 0) begin
          check_value("extra_req", 64'(start_ins_addr), 64'hFFFF_FFFF);
        end else begin
          es = req_s_q.pop_front();
          ee = req_e_q.pop_front();
          check_value("req_start", 64'(start_ins_addr), 64'(es));
          check_value("req_end", 64'(end_ins_addr), 64'(ee));
          if (first_req) check_value("req_latency", 64'(cyc), 64'd1);
          first_req = 0;
          outstanding = 1;
          bbase = int'(es);
          bn = int'(ee) - int'(es) + 1;
          delay = $urandom_range(2, 5);
        end
      end
      if (hold_pending) begin
        check_value("hold_valid", 64'(ins_valid), 64'd1);
        check_value("hold_data", ins_data, held);
      end
      hold_pending = 0;
      if (!ins_valid) check_value("idle_data_zero", ins_data, 64'd0);
      case (mode)
        0: ins_ready = 1'b1;
        1: ins_ready = 1'($urandom_range(0, 1));
        default: ins_ready = ~ins_ready;
      endcase
      if (ins_valid) begin
        if (ins_ready) begin
          if (exp_q.size() == 0) check_value("extra_ins", ins_data, 64'hDEAD_DEAD_DEAD_DEAD);
          else check_value("ins_data", ins_data, exp_q.pop_front());
          if (n_acc == 0) first_acc = cyc;
          last_acc = cyc;
          n_acc++;
        end else begin
          hold_pending = 1;
          held = ins_data;
        end
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (done_cnt > 0 && cyc == done_cyc + 1) check_value("busy_after_done", 64'(busy), 64'd0);
      burst_valid = 1'b0;
      if (outstanding) begin
        delay--;
        if (delay == 0) begin
          burst_valid = 1'b1;
          burst_data = build_burst(bbase, bn);
          outstanding = 0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        burst_valid = 1'b1;
        burst_data = build_burst(0, 0);
      end
      if (mode == 1 && busy && $urandom_range(0, 15) == 0) begin
        start = 1'b1;
        prog_start_addr = 16'($urandom);
        prog_end_addr = 16'($urandom);
      end
      if (done_cnt > 0 && cyc >= done_cyc + 6) break;
    end
    burst_valid = 1'b0;
    start = 1'b0;
    if (done_cnt == 0) check_value("done_timeout", 64'(cyc), 64'd0);
    check_value("done_count", 64'(done_cnt), 64'd1);
    check_value("issued_count", 64'(n_acc), 64'(n_exp));
    check_value("req_left", 64'(req_s_q.size()), 64'd0);
    if (s > e) check_value("empty_done_lat", 64'(done_cyc), 64'd1);
    if (mode == 0 && n_exp > 1 && n_exp <= NS && n_acc == n_exp)
      check_value("b2b_span", 64'(last_acc - first_acc), 64'(n_exp - 1));
  endtask

  // ---------------- driver: reset mid-program ----------------
  task automatic reset_mid(input int accept_n);
    bit found;
    int s;
    s = 16'h0020;
    word_tag = 16'($urandom);
    zero_addr = -1;
    ins_ready = 1'b0;
    @(negedge clk);
    start = 1'b1;
    prog_start_addr = 16'(s);
    prog_end_addr = 16'(s + 15);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (fetch_req) found = 1;
    end
    check_value("rst_req_seen", 64'(found), 64'd1);
    @(negedge clk);
    if (accept_n >= 0) begin
      burst_valid = 1'b1;
      burst_data = build_burst(s, 16);
      @(negedge clk);
      burst_valid = 1'b0;
      for (int i = 0; i < accept_n; i++) begin
        ins_ready = 1'b1;
        @(negedge clk);
      end
      ins_ready = 1'b0;
      check_value("pre_reset_data", ins_data, word(s + accept_n));
    end
    RSTn = 1'b0;
    #1;
    check_all_zero(accept_n < 0 ? "rst_wait" : "rst_issue");
    repeat (2) @(negedge clk);
    RSTn = 1'b1;
    @(negedge clk);
    burst_valid = 1'b1;
    burst_data = build_burst(s, 16);
    @(negedge clk);
    burst_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check_value("post_rst_no_req", 64'(fetch_req), 64'd0);
      check_value("post_rst_no_ins", 64'(ins_valid), 64'd0);
      check_value("post_rst_idle", 64'(busy), 64'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int s, len, z;
    #1;
    check_all_zero("reset");
    repeat (3) @(negedge clk);
    RSTn = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check_value("no_req_before_start", 64'(fetch_req), 64'd0);
    end
    run_program(16'h0000, 16'h0009, 0, -1);
    run_program(16'h0100, 16'h0180, 0, -1);
    run_program(16'h0040, 16'h006F, 2, -1);
    reset_mid(-1);
    reset_mid(5);
    run_program(16'h0010, 16'h001F, 0, -1);
    run_program(16'hFFC0, 16'hFFFF, 0, -1);
    run_program(16'h0005, 16'h0004, 0, -1);
    run_program(16'h0200, 16'h0209, 0, 16'h0203);
    run_program(16'hFFA3, 16'hFFFF, 1, -1);
    for (int t = 0; t < 6; t++) begin
      s = $urandom_range(0, 16'hFE00);
      len = $urandom_range(1, 150);
      z = ($urandom_range(0, 1) == 1) ? s + $urandom_range(0, len - 1) : -1;
      run_program(s, s + len - 1, 1, z);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  // ---------------- final report on runaway ----------------
  initial begin
    #1000000;
    n_checks++;
    n_fails++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
